// File: rtl/cache_param_if.sv
// CPU-side request/response and memory-side read/write channels of cache_param.
// The slave modport is the cache's view; the master modport is the CPU/memory side.
interface cache_param_if #(
   parameter int LINE_WORDS = 4
);
   logic                    valid;
   logic                    op;
   logic                    uncached;
   logic [31:0]             addr;
   logic [3:0]              wstrb;
   logic [31:0]             wdata;
   logic                    addr_ok;
   logic                    data_ok;
   logic [31:0]             rdata;
   logic                    rd_req;
   logic [2:0]              rd_type;
   logic [31:0]             rd_addr;
   logic                    rd_rdy;
   logic                    ret_valid;
   logic                    ret_last;
   logic [31:0]             ret_data;
   logic                    wr_req;
   logic [2:0]              wr_type;
   logic [31:0]             wr_addr;
   logic [3:0]              wr_wstrb;
   logic [32*LINE_WORDS-1:0] wr_data;
   logic                    wr_rdy;

   modport slave (
      input  valid, op, uncached, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
      output addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
   );
   modport master (
      output valid, op, uncached, addr, wstrb, wdata, rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
      input  addr_ok, data_ok, rdata, rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data
   );
endinterface

// File: rtl/cache_param.sv
// Blocking set-associative write-back cache with per-set round-robin replacement
// and an uncached bypass path; one CPU request in flight at a time.
module cache_param #(
   parameter int WAYS     = 2,
   parameter int INDEX_W  = 8,
   parameter int OFFSET_W = 4
) (
   input logic          clk,
   input logic          reset,
   cache_param_if.slave bus
);
   localparam int SETS  = 1 << INDEX_W;
   localparam int LW    = 1 << (OFFSET_W - 2);
   localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int WRD_W = OFFSET_W - 2;

   typedef enum logic [2:0] {IDLE, LOOKUP, WBACK, REPLACE, REFILL} state_e;

   state_e                     state_q, state_d;
   logic                       op_q, op_d, unc_q, unc_d;
   logic [31:0]                addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]                 wstrb_q, wstrb_d;
   logic [WRD_W-1:0]           cnt_q, cnt_d;
   logic [WAY_W-1:0]           victim_q, victim_d;
   logic [SETS-1:0][WAYS-1:0]  valid_q, valid_d, dirty_q, dirty_d;
   logic [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;
   logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
   logic [31:0]                data_q [WAYS][SETS][LW];

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [WRD_W-1:0]   req_word;
   assign req_tag  = addr_q[31 -: TAG_W];
   assign req_idx  = addr_q[OFFSET_W +: INDEX_W];
   assign req_word = addr_q[OFFSET_W-1:2];

   logic             dwe, twe;
   logic [WAY_W-1:0] dwe_way;
   logic [WRD_W-1:0] dwe_word;
   logic [31:0]      dwe_val;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   // Descending scan so the lowest-numbered invalid way wins.
   logic [WAYS-1:0]  hit_vec;
   logic             hit, inv_found;
   logic [WAY_W-1:0] hit_way, inv_way;
   always_comb begin
      hit_vec   = '0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_vec[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag) && !unc_q;
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (!valid_q[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      hit = |hit_vec;
   end

   logic [32*LW-1:0] victim_line;
   always_comb begin
      victim_line = '0;
      for (int i = 0; i < LW; i++) victim_line[32*i +: 32] = data_q[victim_q][req_idx][i];
   end

   assign bus.addr_ok = (state_q == IDLE) && !reset;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      unc_d    = unc_q;
      addr_d   = addr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      victim_d = victim_q;
      valid_d  = valid_q;
      dirty_d  = dirty_q;
      ptr_d    = ptr_q;
      dwe      = 1'b0;
      dwe_way  = victim_q;
      dwe_word = cnt_q;
      dwe_val  = bus.ret_data;
      twe      = 1'b0;
      bus.data_ok  = 1'b0;
      bus.rdata    = '0;
      bus.rd_req   = 1'b0;
      bus.rd_type  = '0;
      bus.rd_addr  = '0;
      bus.wr_req   = 1'b0;
      bus.wr_type  = '0;
      bus.wr_addr  = '0;
      bus.wr_wstrb = '0;
      bus.wr_data  = '0;
      case (state_q)
         IDLE: if (bus.valid) begin
            op_d    = bus.op;
            unc_d   = bus.uncached;
            addr_d  = bus.addr;
            wstrb_d = bus.wstrb;
            wdata_d = bus.wdata;
            state_d = LOOKUP;
         end
         LOOKUP: begin
            if (unc_q) state_d = op_q ? WBACK : REPLACE;
            else if (hit) begin
               bus.data_ok = 1'b1;
               state_d     = IDLE;
               if (op_q) begin
                  dwe      = 1'b1;
                  dwe_way  = hit_way;
                  dwe_word = req_word;
                  dwe_val  = merge(data_q[hit_way][req_idx][req_word], wdata_q, wstrb_q);
                  dirty_d[req_idx][hit_way] = 1'b1;
               end else bus.rdata = data_q[hit_way][req_idx][req_word];
            end else begin
               victim_d = inv_found ? inv_way : ptr_q[req_idx];
               if (!inv_found)
                  ptr_d[req_idx] = (ptr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                 : ptr_q[req_idx] + WAY_W'(1);
               state_d = (valid_q[req_idx][victim_d] && dirty_q[req_idx][victim_d]) ? WBACK : REPLACE;
            end
         end
         WBACK: begin
            bus.wr_req = 1'b1;
            if (unc_q) begin
               bus.wr_type       = 3'b010;
               bus.wr_addr       = addr_q;
               bus.wr_wstrb      = wstrb_q;
               bus.wr_data[31:0] = wdata_q;
               if (bus.wr_rdy) begin
                  bus.data_ok = 1'b1;
                  state_d     = IDLE;
               end
            end else begin
               bus.wr_type  = 3'b100;
               bus.wr_addr  = {tag_q[victim_q][req_idx], req_idx, OFFSET_W'(0)};
               bus.wr_wstrb = 4'hF;
               bus.wr_data  = victim_line;
               if (bus.wr_rdy) state_d = REPLACE;
            end
         end
         REPLACE: begin
            bus.rd_req  = 1'b1;
            bus.rd_type = unc_q ? 3'b010 : 3'b100;
            bus.rd_addr = unc_q ? addr_q : {req_tag, req_idx, OFFSET_W'(0)};
            if (bus.rd_rdy) begin
               state_d = REFILL;
               cnt_d   = '0;
               // Victim goes invalid while being overwritten so an abort leaves no stale line.
               if (!unc_q) begin
                  valid_d[req_idx][victim_q] = 1'b0;
                  dirty_d[req_idx][victim_q] = 1'b0;
               end
            end
         end
         REFILL: if (bus.ret_valid) begin
            if (unc_q) begin
               bus.data_ok = 1'b1;
               bus.rdata   = bus.ret_data;
               state_d     = IDLE;
            end else begin
               dwe   = 1'b1;
               cnt_d = cnt_q + WRD_W'(1);
               if (op_q && cnt_q == req_word) dwe_val = merge(bus.ret_data, wdata_q, wstrb_q);
               if (!op_q && cnt_q == req_word) begin
                  bus.data_ok = 1'b1;
                  bus.rdata   = bus.ret_data;
               end
               if (bus.ret_last) begin
                  twe = 1'b1;
                  valid_d[req_idx][victim_q] = 1'b1;
                  dirty_d[req_idx][victim_q] = op_q;
                  state_d = IDLE;
                  if (op_q) bus.data_ok = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= 1'b0;
         unc_q    <= 1'b0;
         addr_q   <= '0;
         wstrb_q  <= '0;
         wdata_q  <= '0;
         cnt_q    <= '0;
         victim_q <= '0;
         valid_q  <= '0;
         dirty_q  <= '0;
         ptr_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         unc_q    <= unc_d;
         addr_q   <= addr_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         cnt_q    <= cnt_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
         dirty_q  <= dirty_d;
         ptr_q    <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (dwe) data_q[dwe_way][req_idx][dwe_word] <= dwe_val;
      if (twe) tag_q[victim_q][req_idx] <= req_tag;
   end
endmodule

// File: doc/cache_param.md
CACHE_PARAM -- requirements
Module: cache_param

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-002 Parameter INDEX_W, default 8, set-index width (2^INDEX_W sets).
REQ-003 Parameter OFFSET_W, default 4, byte offset width; LINE_WORDS = 2^(OFFSET_W-2), 2..16; TAG_W = 32-INDEX_W-OFFSET_W.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 valid  in  1  CPU request valid.
REQ-007 op  in  1  1 = write, 0 = read.
REQ-008 uncached  in  1  1 = bypass cache for this request.
REQ-009 addr  in  32  byte address {tag,index,offset}.
REQ-010 wstrb  in  4  byte enables for write.
REQ-011 wdata  in  32  write data.
REQ-012 addr_ok  out  1  request accepted this cycle when valid high.
REQ-013 data_ok  out  1  read data valid / write complete, single-cycle pulse.
REQ-014 rdata  out  32  read data, qualified by data_ok.
REQ-015 rd_req  out  1  memory read request; rd_type out 3 (3'b010 word, 3'b100 line); rd_addr out 32.
REQ-016 rd_rdy  in  1  read request accepted.
REQ-017 ret_valid  in  1  return beat valid; ret_last in 1 final beat; ret_data in 32.
REQ-018 wr_req  out  1  memory write request; wr_type out 3; wr_addr out 32; wr_wstrb out 4; wr_data out 32*LINE_WORDS.
REQ-019 wr_rdy  in  1  write request accepted.

Function
REQ-020 Blocking controller, states IDLE, LOOKUP, WBACK, REPLACE, REFILL; one request outstanding.
REQ-021 addr_ok = (state==IDLE); valid&addr_ok latches op, uncached, addr, wstrb, wdata into request buffer; next state LOOKUP.
REQ-022 Storage: per set/way tag, valid, dirty, LINE_WORDS words in flops; per-set round-robin pointer (log2 WAYS bits).
REQ-023 LOOKUP: hit = valid & tag match in any way; at most one way hits; uncached forces miss.
REQ-024 Cached read hit: data_ok=1, rdata = hit-way word at offset[OFFSET_W-1:2], same LOOKUP cycle; next IDLE (latency 2 cycles from accept).
REQ-025 Cached write hit: bytes with wstrb=1 merged into hit-way word at edge leaving LOOKUP, dirty set, data_ok=1 in LOOKUP; next IDLE.
REQ-026 Cached miss victim: lowest-index invalid way, else round-robin pointer way; pointer increments (mod WAYS) only when used.
REQ-027 Cached miss: victim valid&dirty -> WBACK, else -> REPLACE; victim captured at LOOKUP exit.
REQ-028 WBACK (cached): wr_req=1, wr_type=3'b100, wr_addr={victim tag,index,0}, wr_wstrb=4'hF, wr_data=victim line, word 0 in bits[31:0]; held stable until wr_rdy; wr_req&wr_rdy -> REPLACE.
REQ-029 Uncached write: LOOKUP -> WBACK with wr_type=3'b010, wr_addr=addr, wr_wstrb=wstrb, wr_data[31:0]=wdata, upper bits 0; on wr_rdy data_ok=1 same cycle, next IDLE; cache state untouched.
REQ-030 Uncached read: LOOKUP -> REPLACE with rd_type=3'b010, rd_addr=addr; REFILL returns one beat: data_ok=1, rdata=ret_data on ret_valid; next IDLE; no install.
REQ-031 REPLACE (cached): rd_req=1, rd_type=3'b100, rd_addr={tag,index,0}, held until rd_rdy; rd_req&rd_rdy -> REFILL, beat counter cleared.
REQ-032 REFILL: each ret_valid writes ret_data to victim word[counter], counter+1 (wraps at LINE_WORDS); beats in word order 0..LINE_WORDS-1.
REQ-033 Refill read: data_ok=1, rdata=ret_data on beat where counter equals requested word.
REQ-034 Refill write: requested word stored as ret_data merged with wdata per wstrb; data_ok=1 on ret_last beat.
REQ-035 ret_valid&ret_last: install tag, valid=1, dirty=op; next IDLE regardless of counter; ret_valid low stalls without state change.
REQ-036 data_ok exactly one cycle per accepted request; rd_req/wr_req never simultaneously high.
REQ-037 Outputs not named above drive 0 in each state.

Reset
REQ-038 reset high: state IDLE, all valid/dirty/pointers 0, counter 0, request buffer 0; takes effect immediately, irrespective of clk.
REQ-039 During reset addr_ok, data_ok, rd_req, wr_req, rdata, all addresses 0; reset mid-REFILL or mid-WBACK abandons transaction, no partial install.
REQ-040 First cycle after reset deassertion: addr_ok=1.

Verification
REQ-041 Cold read 0x0000_1004 (WAYS=2), rd_rdy=1, beats 0x10..0x13 -> rd_addr 0x0000_1000, type 3'b100, data_ok on beat 1 with rdata 0x11; reread -> hit data_ok 2 cycles after accept, rdata 0x11.
REQ-042 Write hit 0x0000_1008 wstrb 4'b0011 wdata 0xAABB_CCDD over 0x12 -> later read returns 0x0000_CCDD; line dirty.
REQ-043 Fill set 0 with tags A,B (A dirty), miss tag C -> victim way0 (pointer 0): wr_addr {A,0,0}, type 3'b100, full line; then rd_req; pointer becomes 1; wr_req held 3 cycles with wr_rdy low.
REQ-044 Uncached write 0x1FD0_0000 wstrb 4'hF, wdata 0x1 -> wr_type 3'b010, wr_wstrb 4'hF, data_ok on wr_rdy; no tag change; uncached read -> rd_type 3'b010, rdata = single beat.
REQ-045 Assert reset during REFILL beat 2 -> outputs 0 same cycle; after release addr_ok=1, prior target line reads as miss.
